// File: rtl/frac_dec_pkg.sv
// frac_dec_pkg: shared widths, FSM state encoding and leading-zero helper for frac_dec_ctrl
package frac_dec_pkg;
  localparam int FRAC_W     = 24;
  localparam int NUM_DIGITS = 5;
  localparam int DIG_W      = 4;
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ITER  = 2'd1;
  localparam logic [1:0] S_ROUND = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;
  function automatic logic [2:0] count_lz(input logic [NUM_DIGITS*DIG_W-1:0] d);
    logic [2:0] n;
    logic stop;
    n = 3'd0;
    stop = 1'b0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      stop = stop | (d[i*DIG_W +: DIG_W] != 4'd0);
      n = n + {2'b00, ~stop};
    end
    return (n > 3'd4) ? 3'd4 : n;
  endfunction
endpackage

// File: rtl/bcd_inc5.sv
// bcd_inc5: combinational 5-digit BCD increment with carry-out
module bcd_inc5
  import frac_dec_pkg::*;
(
  input  logic [NUM_DIGITS*DIG_W-1:0] d,
  output logic [NUM_DIGITS*DIG_W-1:0] q,
  output logic                        co
);
  always_comb begin
    q = d;
    co = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      q[i*DIG_W +: DIG_W] = co ? ((d[i*DIG_W +: DIG_W] == 4'd9) ? 4'd0 : d[i*DIG_W +: DIG_W] + 4'd1)
                               : d[i*DIG_W +: DIG_W];
      co = co & (d[i*DIG_W +: DIG_W] == 4'd9);
    end
  end
endmodule

// File: rtl/frac_dec_ctrl.sv
// frac_dec_ctrl: converts a 24-bit binary fraction to five BCD digits by repeated x10.
// Define FRAC_DEC_ROUND_EN for round-half-up on a guard digit; otherwise digits are truncated.
module frac_dec_ctrl
  import frac_dec_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [FRAC_W-1:0]           frac,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [NUM_DIGITS*DIG_W-1:0] digits,
  output logic [2:0]                  lead_zeros,
  output logic                        carry,
  output logic                        busy
);
  logic [1:0] state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [FRAC_W-1:0] rem_q, rem_d;
  logic [NUM_DIGITS*DIG_W-1:0] digits_q, digits_d;
  logic [2:0] lz_q, lz_d;
  logic [FRAC_W+3:0] p;
`ifdef FRAC_DEC_ROUND_EN
  localparam logic [2:0] N_ITER = 3'd6;
  logic [DIG_W-1:0] guard_q, guard_d;
  logic carry_q, carry_d;
  logic [NUM_DIGITS*DIG_W-1:0] inc_q;
  logic inc_co;
  bcd_inc5 u_inc (.d(digits_q), .q(inc_q), .co(inc_co));
  assign carry = carry_q;
`else
  localparam logic [2:0] N_ITER = 3'd5;
  assign carry = 1'b0;
`endif
  assign p = ({4'b0000, rem_q} << 3) + ({4'b0000, rem_q} << 1);
  assign in_ready = state_q == S_IDLE;
  assign busy = state_q != S_IDLE;
  assign out_valid = state_q == S_DONE;
  assign digits = digits_q;
  assign lead_zeros = lz_q;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    rem_d = rem_q;
    digits_d = digits_q;
    lz_d = lz_q;
`ifdef FRAC_DEC_ROUND_EN
    guard_d = guard_q;
    carry_d = carry_q;
`endif
    if (state_q == S_IDLE && in_valid) begin
      state_d = S_ITER;
      rem_d = frac;
      cnt_d = 3'd0;
      lz_d = 3'd0;
`ifdef FRAC_DEC_ROUND_EN
      carry_d = 1'b0;
`endif
    end else if (state_q == S_ITER) begin
      rem_d = p[FRAC_W-1:0];
      if (cnt_q < 3'(NUM_DIGITS)) digits_d = {digits_q[(NUM_DIGITS-1)*DIG_W-1:0], p[FRAC_W+3:FRAC_W]};
`ifdef FRAC_DEC_ROUND_EN
      else guard_d = p[FRAC_W+3:FRAC_W];
`endif
      cnt_d = (cnt_q == N_ITER - 3'd1) ? 3'd0 : cnt_q + 3'd1;
      state_d = (cnt_q == N_ITER - 3'd1) ? S_ROUND : S_ITER;
    end else if (state_q == S_ROUND) begin
`ifdef FRAC_DEC_ROUND_EN
      // first ROUND cycle applies the increment, second derives lead_zeros from the result
      if (cnt_q == 3'd0) begin
        cnt_d = 3'd1;
        digits_d = (guard_q >= 4'd5) ? inc_q : digits_q;
        carry_d = (guard_q >= 4'd5) & inc_co;
      end else begin
        cnt_d = 3'd0;
        lz_d = count_lz(digits_q);
        state_d = S_DONE;
      end
`else
      lz_d = count_lz(digits_q);
      state_d = S_DONE;
`endif
    end else if (state_q == S_DONE && out_ready) begin
      state_d = S_IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q <= 3'd0;
      rem_q <= '0;
      digits_q <= '0;
      lz_q <= 3'd0;
`ifdef FRAC_DEC_ROUND_EN
      guard_q <= '0;
      carry_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      rem_q <= rem_d;
      digits_q <= digits_d;
      lz_q <= lz_d;
`ifdef FRAC_DEC_ROUND_EN
      guard_q <= guard_d;
      carry_q <= carry_d;
`endif
    end
  end
endmodule

// File: tb/tb_frac_dec_ctrl.sv
// tb_frac_dec_ctrl: directed + random conversions checked against an arithmetic reference model
module tb_frac_dec_ctrl;
`ifdef FRAC_DEC_ROUND_EN
  localparam bit ROUND = 1'b1;
  localparam int LAT = 8;
`else
  localparam bit ROUND = 1'b0;
  localparam int LAT = 6;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [23:0] frac = '0;
  logic out_valid;
  logic out_ready = 1'b0;
  logic [19:0] digits;
  logic [2:0] lead_zeros;
  logic carry;
  logic busy;
  int n_checks = 0;
  int n_fails = 0;

  frac_dec_ctrl dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .frac(frac),
    .out_valid(out_valid), .out_ready(out_ready), .digits(digits), .lead_zeros(lead_zeros),
    .carry(carry), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Decimal value of the fraction scaled by 10^5, rounded or truncated, then split into BCD digits
  task automatic model(input logic [23:0] f, output logic [19:0] d, output logic [2:0] lz, output logic c);
    longint v;
    longint s6;
    s6 = (longint'(f) * 64'd1000000) >> 24;
    c = 1'b0;
    if (ROUND) begin
      v = s6 / 10;
      if (s6 % 10 >= 5) v = v + 1;
      if (v == 100000) begin
        c = 1'b1;
        v = 0;
      end
    end else begin
      v = (longint'(f) * 64'd100000) >> 24;
    end
    for (int i = 0; i < 5; i++) begin
      d[i*4 +: 4] = 4'(v % 10);
      v = v / 10;
    end
    lz = 3'd0;
    for (int i = 4; i >= 0; i--) begin
      if (d[i*4 +: 4] != 4'd0) break;
      lz = lz + 3'd1;
    end
    if (lz > 3'd4) lz = 3'd4;
  endtask

  task automatic convert(input logic [23:0] f, input int hold);
    logic [19:0] ed;
    logic [2:0] elz;
    logic ec;
    int cyc;
    model(f, ed, elz, ec);
    chk("in_ready_idle", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    frac = f;
    tick();
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      in_valid = 1'($urandom_range(0, 1));
      frac = 24'($urandom);
      chk("busy_in_ready", 32'(in_ready), 32'd0);
      tick();
      cyc++;
    end
    in_valid = 1'b0;
    chk("latency", 32'(cyc), 32'(LAT));
    chk("digits", 32'(digits), 32'(ed));
    chk("lead_zeros", 32'(lead_zeros), 32'(elz));
    chk("carry", 32'(carry), 32'(ec));
    for (int i = 0; i < hold; i++) begin
      tick();
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_digits", 32'(digits), 32'(ed));
      chk("hold_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("post_valid", 32'(out_valid), 32'd0);
    chk("post_in_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    tick();
    tick();
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_digits", 32'(digits), 32'd0);
    rst_n = 1'b1;
    tick();
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    convert(24'h800000, 0);
    convert(24'h001000, 1);
    convert(24'hFFFFFF, 0);
    convert(24'h400000, 10);
    convert(24'h000000, 0);
    convert(24'h19999A, 0);
    for (int k = 0; k < 10; k++) convert(24'($urandom), int'($urandom_range(0, 3)));
    in_valid = 1'b1;
    frac = 24'h123456;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_valid", 32'(out_valid), 32'd0);
    chk("abort_digits", 32'(digits), 32'd0);
    chk("abort_lz", 32'(lead_zeros), 32'd0);
    chk("abort_carry", 32'(carry), 32'd0);
    tick();
    chk("abort_no_valid", 32'(out_valid), 32'd0);
    convert(24'h000001, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
